pwm_capture: RTL

- Input-capture unit: receiver side of the PWM timer's output.
- Samples an external PWM line and measures its period and high time in i_clk cycles.
- Counts a programmed number of complete periods, then raises a completion flag.
- Results are exposed through a small addressed register interface, the read/write counterpart of the timer's write-only port; it sits alongside the timer on the same register bus.

---
 rtl/pwm_pkg.sv | 21 ++
 rtl/pwm_edge_sync.sv | 33 +++
 rtl/pwm_capture.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM register map, status bits and capture states.
// Used by the PWM timer and the capture unit on the same bus.
package pwm_pkg;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_HIGH   = 2'd1;
  localparam logic [1:0] ADDR_CYCLES = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int ST_DONE = 0;
  localparam int ST_OVF  = 1;
  localparam int ST_BUSY = 2;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'd0,
    CAP_ARM     = 2'd1,
    CAP_MEASURE = 2'd2,
    CAP_DONE    = 2'd3
  } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes i_pwm and flags rising/falling edges.
// Ports: i_clk, i_rstn, i_pwm in; o_rise, o_fall one-cycle pulses out.
module pwm_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_pwm,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pwm};
      dly_q  <= sync;
    end
  end

  // Both edges come from the same sync/dly pair, so latency matches.
  assign o_rise = sync & ~dly_q;
  assign o_fall = ~sync & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period/high time over CYCLES periods.
// Ports: i_clk, i_rstn, i_pwm, i_start, i_we/i_re/i_addr/i_wdata, o_rdata, o_capture_done, o_busy.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_pwm,
  input  logic             i_start,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [1:0]       i_addr,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [CNT_W-1:0] o_rdata,
  output logic             o_capture_done,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cap_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] seen_q, seen_d;
  logic [CNT_W-1:0] rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q, pulse_d;

  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] eff_cyc;
  logic [CNT_W-1:0] seen_inc;
  logic [CNT_W-1:0] status;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk (i_clk),
    .i_rstn(i_rstn),
    .i_pwm (i_pwm),
    .o_rise(rise),
    .o_fall(fall)
  );

  // A zero target still needs one full period.
  assign eff_cyc  = (cycles_q == '0) ? CNT_ONE : cycles_q;
  assign seen_inc = seen_q + CNT_ONE;

  always_comb begin
    status          = '0;
    status[ST_DONE] = done_q;
    status[ST_OVF]  = ovf_q;
    status[ST_BUSY] = busy_q;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= CAP_IDLE;
      busy_q   <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      cycles_q <= '0;
      cnt_q    <= '0;
      seen_q   <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      period_q <= period_d;
      high_q   <= high_d;
      cycles_q <= cycles_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    cycles_d = cycles_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    rdata_d  = rdata_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    pulse_d  = 1'b0;

    unique case (state_q)
      CAP_IDLE, CAP_DONE: begin
        if (i_start) begin
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          seen_d  = '0;
          state_d = CAP_ARM;
        end
      end
      CAP_ARM: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = CAP_MEASURE;
        end
      end
      CAP_MEASURE: begin
        cnt_d = cnt_q + CNT_ONE;
        // A rise on the saturating cycle still closes a valid period.
        if (rise) begin
          period_d = cnt_q;
          cnt_d    = CNT_ONE;
          seen_d   = seen_inc;
          if (seen_inc >= eff_cyc) begin
            done_d  = 1'b1;
            pulse_d = 1'b1;
            state_d = CAP_DONE;
          end
        end else if (cnt_q == '1) begin
          ovf_d   = 1'b1;
          done_d  = 1'b1;
          pulse_d = 1'b1;
          state_d = CAP_DONE;
        end else if (fall) begin
          high_d = cnt_q;
        end
      end
      default: state_d = CAP_IDLE;
    endcase

    if (i_we && (i_addr == ADDR_CYCLES) && !busy_q) begin
      cycles_d = i_wdata;
    end

    // Reads see register values from before this cycle's update.
    if (i_re) begin
      unique case (i_addr)
        ADDR_PERIOD: rdata_d = period_q;
        ADDR_HIGH:   rdata_d = high_q;
        ADDR_CYCLES: rdata_d = cycles_q;
        ADDR_STATUS: rdata_d = status;
        default:     rdata_d = '0;
      endcase
    end

    busy_d = (state_d == CAP_ARM) || (state_d == CAP_MEASURE);
  end

  assign o_rdata        = rdata_q;
  assign o_capture_done = pulse_q;
  assign o_busy         = busy_q;

endmodule
